// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
//   Front end for the clock's set controls. Synchronizes and debounces the
//   three raw push-buttons and produces the set-mode register plus one-cycle
//   increment/decrement strobes with hold-to-auto-repeat.
//
// Ports
//   clk        : divided system clock, all state on the rising edge
//   reset      : asynchronous, active-low reset
//   sw         : raw mode button, active-high
//   increase   : raw increase button, active-low
//   decrease   : raw decrease button, active-low
//   mode       : 00 run, 01 set hour, 10 set minute, 11 set second
//   mode_pulse : one-cycle strobe on every mode advance
//   increment  : one-cycle increment strobe
//   decrement  : one-cycle decrement strobe
// -----------------------------------------------------------------------------
module key_conditioner #(
   parameter int unsigned DEB_CYCLES    = 20000,
   parameter int unsigned HOLD_CYCLES   = 500000,
   parameter int unsigned REPEAT_CYCLES = 250000,
   parameter int unsigned CNT_W         = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sw,
   input  logic       increase,
   input  logic       decrease,
   output logic [1:0] mode,
   output logic       mode_pulse,
   output logic       increment,
   output logic       decrement
);

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

   // Bit order everywhere: [0] sw, [1] increase, [2] decrease.
   // Raw released levels are sw=0, increase=1, decrease=1.
   localparam logic [2:0] RAW_IDLE = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_REPEAT,
      ST_LOCK
   } state_t;

   logic [2:0]       raw;
   logic [2:0]       sync1_q, sync2_q;
   logic [2:0]       lvl;          // synchronized, 1 = pressed
   logic [2:0]       deb_q;        // debounced, 1 = pressed
   logic [CNT_W-1:0] deb_cnt_q [3];
   logic [1:0]       primed_q;
   logic [2:0]       armed_q;
   logic [2:0]       pressed;      // debounced and armed
   logic             sw_prev_q;
   logic             sw_rise;

   logic [1:0]       mode_q;
   logic             mode_pulse_q;

   state_t           state_q;
   logic [CNT_W-1:0] rpt_cnt_q;
   logic [CNT_W-1:0] rpt_last;
   logic             dir_inc_q;
   logic             inc_q, dec_q;
   logic             held, other;

   assign raw = {decrease, increase, sw};
   assign lvl = sync2_q ^ RAW_IDLE;

   // -------------------------------------------------------------------------
   // Synchronizers and per-button debounce
   // -------------------------------------------------------------------------
   // A button only becomes usable ("armed") once it has been seen released,
   // both synchronized and debounced, with the synchronizer holding real
   // samples rather than its reset value. A button held through reset is
   // therefore ignored until it is released and pressed again.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q  <= RAW_IDLE;
         sync2_q  <= RAW_IDLE;
         deb_q    <= '0;
         primed_q <= '0;
         armed_q  <= '0;
         for (int unsigned i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
      end else begin
         sync1_q  <= raw;
         sync2_q  <= sync1_q;
         primed_q <= {primed_q[0], 1'b1};
         for (int unsigned i = 0; i < 3; i++) begin
            if (lvl[i] != deb_q[i]) begin
               if (deb_cnt_q[i] == DEB_LAST) begin
                  deb_q[i]     <= lvl[i];
                  deb_cnt_q[i] <= '0;
               end else begin
                  deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
               end
            end else begin
               deb_cnt_q[i] <= '0;
            end
            if (primed_q[1] && !lvl[i] && !deb_q[i]) armed_q[i] <= 1'b1;
         end
      end
   end

   assign pressed = deb_q & armed_q;
   assign sw_rise = pressed[0] & ~sw_prev_q;

   // -------------------------------------------------------------------------
   // Mode register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sw_prev_q    <= 1'b0;
         mode_q       <= '0;
         mode_pulse_q <= 1'b0;
      end else begin
         sw_prev_q    <= pressed[0];
         mode_pulse_q <= sw_rise;
         if (sw_rise) mode_q <= mode_q + 2'd1;
      end
   end

   // -------------------------------------------------------------------------
   // Repeat FSM
   // -------------------------------------------------------------------------
   always_comb begin
      rpt_last = (state_q == ST_HOLD) ? HOLD_LAST : REP_LAST;
      held     = dir_inc_q ? pressed[1] : pressed[2];
      other    = dir_inc_q ? pressed[2] : pressed[1];
   end

   // Release is checked before the second-button/mode lock, and both before
   // the period expiry, so a strobe is never issued on a cycle that leaves
   // HOLD/REPEAT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         rpt_cnt_q <= '0;
         dir_inc_q <= 1'b0;
         inc_q     <= 1'b0;
         dec_q     <= 1'b0;
      end else begin
         inc_q <= 1'b0;
         dec_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (pressed[1] && pressed[2]) begin
                  state_q <= ST_LOCK;
               end else if (pressed[1] || pressed[2]) begin
                  inc_q     <= pressed[1];
                  dec_q     <= pressed[2];
                  dir_inc_q <= pressed[1];
                  rpt_cnt_q <= '0;
                  state_q   <= ST_HOLD;
               end
            end
            ST_HOLD, ST_REPEAT: begin
               if (!held) begin
                  state_q <= ST_IDLE;
               end else if (other || sw_rise) begin
                  state_q <= ST_LOCK;
               end else if (rpt_cnt_q == rpt_last) begin
                  inc_q     <= dir_inc_q;
                  dec_q     <= ~dir_inc_q;
                  rpt_cnt_q <= '0;
                  state_q   <= ST_REPEAT;
               end else begin
                  rpt_cnt_q <= rpt_cnt_q + 1'b1;
               end
            end
            ST_LOCK: begin
               if (!pressed[1] && !pressed[2]) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign mode       = mode_q;
   assign mode_pulse = mode_pulse_q;
   assign increment  = inc_q;
   assign decrement  = dec_q;

endmodule

// File: tb/tb_key_conditioner.sv
// -----------------------------------------------------------------------------
// tb_key_conditioner
//   Directed self-checking bench for key_conditioner with small timing
//   parameters (DEB=4, HOLD=20, REPEAT=8). Inputs change 1 ns after a rising
//   edge; k counts rising edges since the last input change, and outputs are
//   sampled 1 ns after edge k.
// -----------------------------------------------------------------------------
module tb_key_conditioner;

   logic       clk = 1'b0;
   logic       reset;
   logic       sw;
   logic       increase;
   logic       decrease;
   logic [1:0] mode;
   logic       mode_pulse;
   logic       increment;
   logic       decrement;

   int checks = 0;
   int errors = 0;

   key_conditioner #(
      .DEB_CYCLES   (4),
      .HOLD_CYCLES  (20),
      .REPEAT_CYCLES(8),
      .CNT_W        (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .sw        (sw),
      .increase  (increase),
      .decrease  (decrease),
      .mode      (mode),
      .mode_pulse(mode_pulse),
      .increment (increment),
      .decrement (decrement)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; sw = 1'b0; increase = 1'b1; decrease = 1'b1;
      tick(); tick();
      checks++;
      if ({mode, mode_pulse, increment, decrement} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_state got %b exp 00000", {mode, mode_pulse, increment, decrement});
      end
      reset = 1'b1;
      for (int k = 0; k < 5; k++) tick();
   endtask

   task automatic test_mode();
      logic [1:0] exp_mode;
      exp_mode = 2'b00;
      for (int p = 0; p < 5; p++) begin
         exp_mode = exp_mode + 2'd1;
         sw = 1'b1;
         for (int k = 1; k <= 22; k++) begin
            tick();
            if (k == 10) sw = 1'b0;
            checks++;
            if (mode_pulse !== (k == 7)) begin
               errors++;
               $display("FAIL mode_pulse press %0d k=%0d got %b exp %b", p, k, mode_pulse, (k == 7));
            end
            if (k == 7 || k == 22) begin
               checks++;
               if (mode !== exp_mode) begin
                  errors++;
                  $display("FAIL mode_value press %0d k=%0d got %b exp %b", p, k, mode, exp_mode);
               end
            end
         end
      end
      // mode is 01 here; asynchronous reset mid-cycle
      #3 reset = 1'b0;
      #1;
      checks++;
      if (mode !== 2'b00 || mode_pulse !== 1'b0) begin
         errors++;
         $display("FAIL mode_async_reset got mode %b pulse %b exp 00 0", mode, mode_pulse);
      end
      #2 reset = 1'b1;
      for (int k = 0; k < 5; k++) tick();
   endtask

   task automatic test_glitch();
      increase = 1'b0;
      for (int k = 1; k <= 23; k++) begin
         tick();
         if (k == 3) increase = 1'b1;
         checks++;
         if (increment !== 1'b0 || decrement !== 1'b0) begin
            errors++;
            $display("FAIL glitch k=%0d got inc %b dec %b exp 0 0", k, increment, decrement);
         end
      end
   endtask

   task automatic test_hold_repeat();
      logic exp_i;
      increase = 1'b0;
      for (int k = 1; k <= 90; k++) begin
         tick();
         if (k == 60) increase = 1'b1;
         exp_i = (k == 7 || k == 27 || k == 35 || k == 43 || k == 51 || k == 59);
         checks++;
         if (increment !== exp_i || decrement !== 1'b0) begin
            errors++;
            $display("FAIL hold_repeat k=%0d got inc %b dec %b exp %b 0", k, increment, decrement, exp_i);
         end
      end
   endtask

   task automatic test_tap();
      decrease = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (k == 6) decrease = 1'b1;
         checks++;
         if (decrement !== (k == 7) || increment !== 1'b0) begin
            errors++;
            $display("FAIL tap k=%0d got dec %b inc %b exp %b 0", k, decrement, increment, (k == 7));
         end
      end
   endtask

   task automatic test_lock();
      logic exp_i;
      increase = 1'b0;
      for (int k = 1; k <= 80; k++) begin
         tick();
         if (k == 44) decrease = 1'b0;
         // decrease lands on the edge where the next repeat strobe was due (51)
         exp_i = (k == 7 || k == 27 || k == 35 || k == 43);
         checks++;
         if (increment !== exp_i || decrement !== 1'b0) begin
            errors++;
            $display("FAIL lock k=%0d got inc %b dec %b exp %b 0", k, increment, decrement, exp_i);
         end
      end
      increase = 1'b1; decrease = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         checks++;
         if (increment !== 1'b0 || decrement !== 1'b0) begin
            errors++;
            $display("FAIL lock_release k=%0d got inc %b dec %b exp 0 0", k, increment, decrement);
         end
      end
      increase = 1'b0;
      for (int k = 1; k <= 27; k++) begin
         tick();
         if (k == 15) increase = 1'b1;
         checks++;
         if (increment !== (k == 7) || decrement !== 1'b0) begin
            errors++;
            $display("FAIL lock_fresh k=%0d got inc %b dec %b exp %b 0", k, increment, decrement, (k == 7));
         end
      end
   endtask

   task automatic test_mode_lock();
      increase = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (k == 10) sw = 1'b1;
         if (k == 20) sw = 1'b0;
         checks++;
         if (increment !== (k == 7) || mode_pulse !== (k == 17)) begin
            errors++;
            $display("FAIL mode_lock k=%0d got inc %b pulse %b exp %b %b", k, increment, mode_pulse, (k == 7), (k == 17));
         end
         if (k == 17) begin
            checks++;
            if (mode !== 2'b01) begin
               errors++;
               $display("FAIL mode_lock_value got %b exp 01", mode);
            end
         end
      end
      increase = 1'b1;
      for (int k = 1; k <= 12; k++) tick();
      increase = 1'b0;
      for (int k = 1; k <= 27; k++) begin
         tick();
         if (k == 15) increase = 1'b1;
         checks++;
         if (increment !== (k == 7)) begin
            errors++;
            $display("FAIL mode_lock_fresh k=%0d got %b exp %b", k, increment, (k == 7));
         end
      end
   endtask

   task automatic test_reset_repeat();
      increase = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         checks++;
         if (increment !== (k == 7 || k == 27 || k == 35)) begin
            errors++;
            $display("FAIL rst_rpt_pre k=%0d got %b", k, increment);
         end
      end
      #3 reset = 1'b0;
      #1;
      checks++;
      if ({mode, mode_pulse, increment, decrement} !== 5'b00000) begin
         errors++;
         $display("FAIL rst_rpt_async got %b exp 00000", {mode, mode_pulse, increment, decrement});
      end
      #2 reset = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         checks++;
         if (increment !== 1'b0 || mode !== 2'b00) begin
            errors++;
            $display("FAIL rst_rpt_held k=%0d got inc %b mode %b exp 0 00", k, increment, mode);
         end
      end
      increase = 1'b1;
      for (int k = 1; k <= 12; k++) tick();
      increase = 1'b0;
      for (int k = 1; k <= 27; k++) begin
         tick();
         if (k == 15) increase = 1'b1;
         checks++;
         if (increment !== (k == 7)) begin
            errors++;
            $display("FAIL rst_rpt_fresh k=%0d got %b exp %b", k, increment, (k == 7));
         end
      end
   endtask

   initial begin
      test_reset();
      test_mode();
      test_glitch();
      test_hold_repeat();
      test_tap();
      test_lock();
      test_mode_lock();
      test_reset_repeat();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
